writeback_scoreboard: RTL and testbench

//  - Last pipeline stage: latches MEM-stage results and drives the single register-file write port.
//  - Keeps a per-register pending-write scoreboard: decode increments it when it issues, and writeback

---
 rtl/writeback_scoreboard_pkg.sv | 31 +++
 rtl/writeback_scoreboard_if.sv | 54 +++++
 rtl/writeback_scoreboard_sb_counter.sv | 48 ++++
 rtl/writeback_scoreboard.sv | 99 +++++++++
 tb/tb_writeback_scoreboard.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_scoreboard_pkg
//  Description : Shared sizes, types and helpers for the writeback stage and
//                its per-register pending-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package writeback_scoreboard_pkg;

  localparam int NREGS = 16;  // architectural registers
  localparam int AW    = 4;   // register address width
  localparam int DW    = 32;  // data width
  localparam int CW    = 2;   // pending counter width

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] data_t;
  typedef logic [CW-1:0] cnt_t;

  // Largest number of in-flight writers one register can track.
  localparam cnt_t CNT_MAX = '1;

  // One-hot select for a register address; every register is real, R0 included.
  function automatic logic [NREGS-1:0] addr_onehot(input reg_addr_t a);
    logic [NREGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_scoreboard_if
//  Description : Decode/MEM-facing bus of the writeback scoreboard: issue,
//                hazard queries, MEM result and register-file write port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface writeback_scoreboard_if;
  import writeback_scoreboard_pkg::*;

  // decode issue
  logic      issue_valid;
  logic      issue_writes;
  reg_addr_t issue_dest;
  logic      issue_block;
  // decode hazard queries
  reg_addr_t qa_addr;
  reg_addr_t qb_addr;
  logic      qb_en;
  logic      haz_a;
  logic      haz_b;
  // MEM-stage result
  logic      mem_valid;
  logic      mem_writes;
  reg_addr_t mem_dest;
  data_t     mem_data;
  // register-file write port and WB status
  logic      rf_we;
  reg_addr_t rf_waddr;
  data_t     rf_wdata;
  reg_addr_t Daddr_fromWB;
  logic      wb_dvalid;
  logic      sb_underflow;

  // Pipeline side: decode and MEM drive requests, observe WB state.
  modport master (
    output issue_valid, issue_writes, issue_dest,
    output qa_addr, qb_addr, qb_en,
    output mem_valid, mem_writes, mem_dest, mem_data,
    input  issue_block, haz_a, haz_b,
    input  rf_we, rf_waddr, rf_wdata, Daddr_fromWB, wb_dvalid, sb_underflow
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_writes, issue_dest,
    input  qa_addr, qb_addr, qb_en,
    input  mem_valid, mem_writes, mem_dest, mem_data,
    output issue_block, haz_a, haz_b,
    output rf_we, rf_waddr, rf_wdata, Daddr_fromWB, wb_dvalid, sb_underflow
  );

endinterface
`default_nettype wire

// File: rtl/writeback_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sb_counter
//  Description : Saturating up/down pending-writer counter for one register.
//                Simultaneous inc and dec cancel; dec at zero holds zero and
//                flags underflow for the sticky status bit upstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_counter
  import writeback_scoreboard_pkg::*;
(
  input  wire  clk,
  input  wire  rst,
  input  logic inc,
  input  logic dec,
  output logic sat,
  output logic zero,
  output logic underflow
);

  cnt_t count_q;
  cnt_t count_d;

  assign sat       = (count_q == CNT_MAX);
  assign zero      = (count_q == '0);
  assign underflow = dec & zero;

  // Next count: a lone inc steps up unless saturated, a lone dec steps down unless empty.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && !sat) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && !zero) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/writeback_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_scoreboard
//  Description : Writeback stage. Latches MEM results into the single
//                register-file write port and keeps a pending-write counter
//                per register that decode uses for operand hazard checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_scoreboard
  import writeback_scoreboard_pkg::*;
(
  input wire clk,
  input wire rst,
  writeback_scoreboard_if.slave sb
);

  // WB latch state
  logic      rf_we_q,        rf_we_d;
  reg_addr_t rf_waddr_q,     rf_waddr_d;
  data_t     rf_wdata_q,     rf_wdata_d;
  logic      sb_underflow_q, sb_underflow_d;

  // Counter array control/status
  logic [NREGS-1:0] inc_vec;
  logic [NREGS-1:0] dec_vec;
  logic [NREGS-1:0] sat_vec;
  logic [NREGS-1:0] zero_vec;
  logic [NREGS-1:0] unf_vec;
  logic             inc;

  // Stall only a register-writing issue whose destination is already full.
  assign sb.issue_block = sb.issue_valid & sb.issue_writes & sat_vec[sb.issue_dest];
  assign inc            = sb.issue_valid & sb.issue_writes & ~sat_vec[sb.issue_dest];

  // Address decoders: issue increments its destination, the retiring write decrements its own.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc) begin
      inc_vec = addr_onehot(sb.issue_dest);
    end
    if (rf_we_q) begin
      dec_vec = addr_onehot(rf_waddr_q);
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_cnt
    sb_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_vec[i]),
      .dec       (dec_vec[i]),
      .sat       (sat_vec[i]),
      .zero      (zero_vec[i]),
      .underflow (unf_vec[i])
    );
  end

  // Hazard queries see registered counts only, so a register being written still reports busy.
  assign sb.haz_a = ~zero_vec[sb.qa_addr];
  assign sb.haz_b = sb.qb_en & ~zero_vec[sb.qb_addr];

  // WB latch next state: load on a register-writing MEM result, otherwise drop we and hold addr/data.
  always_comb begin
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    sb_underflow_d = sb_underflow_q | (|unf_vec);
    if (sb.mem_valid && sb.mem_writes) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = sb.mem_dest;
      rf_wdata_d = sb.mem_data;
    end
  end

  // WB latch and sticky underflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      sb_underflow_q <= 1'b0;
    end else begin
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      sb_underflow_q <= sb_underflow_d;
    end
  end

  assign sb.rf_we        = rf_we_q;
  assign sb.rf_waddr     = rf_waddr_q;
  assign sb.rf_wdata     = rf_wdata_q;
  assign sb.Daddr_fromWB = rf_waddr_q;
  assign sb.wb_dvalid    = rf_we_q;
  assign sb.sb_underflow = sb_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_scoreboard
//  Description : Self-checking bench for writeback_scoreboard: directed table,
//                mid-flight reset sequence and constrained-random traffic
//                against a count-per-register reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_scoreboard;
  import writeback_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_scoreboard_if bus ();

  writeback_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending writers per register and the WB latch contents.
  int        m_cnt [NREGS];
  bit        m_we;
  int        m_waddr;
  logic [31:0] m_wdata;
  bit        m_unf;

  typedef struct {
    logic iv, iw; logic [3:0] idest;
    logic [3:0] qa, qb; logic qben;
    logic mv, mw; logic [3:0] mdest; logic [31:0] mdata;
    logic e_blk, e_ha, e_hb, e_we; logic [3:0] e_waddr; logic [31:0] e_wdata; logic e_unf;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(
    logic iv, logic iw, logic [3:0] idest, logic [3:0] qa, logic [3:0] qb, logic qben,
    logic mv, logic mw, logic [3:0] mdest, logic [31:0] mdata,
    logic e_blk, logic e_ha, logic e_hb, logic e_we, logic [3:0] e_waddr,
    logic [31:0] e_wdata, logic e_unf);
    vec_t v;
    v.iv = iv; v.iw = iw; v.idest = idest; v.qa = qa; v.qb = qb; v.qben = qben;
    v.mv = mv; v.mw = mw; v.mdest = mdest; v.mdata = mdata;
    v.e_blk = e_blk; v.e_ha = e_ha; v.e_hb = e_hb; v.e_we = e_we;
    v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic iw, input logic [3:0] idest,
                       input logic [3:0] qa, input logic [3:0] qb, input logic qben,
                       input logic mv, input logic mw, input logic [3:0] mdest,
                       input logic [31:0] mdata);
    bus.issue_valid = iv; bus.issue_writes = iw; bus.issue_dest = idest;
    bus.qa_addr = qa; bus.qb_addr = qb; bus.qb_en = qben;
    bus.mem_valid = mv; bus.mem_writes = mw; bus.mem_dest = mdest; bus.mem_data = mdata;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
    m_we = 0; m_waddr = 0; m_wdata = '0; m_unf = 0;
  endtask

  // Apply one clock edge worth of rules to the model using the inputs held on the bus.
  task automatic model_step();
    bit blk, inc;
    int d;
    if (rst) begin
      model_reset();
      return;
    end
    d   = int'(bus.issue_dest);
    blk = bus.issue_valid && bus.issue_writes && (m_cnt[d] == 3);
    inc = bus.issue_valid && bus.issue_writes && !blk;
    if (!(inc && m_we && d == m_waddr)) begin
      if (inc) m_cnt[d]++;
      if (m_we) begin
        if (m_cnt[m_waddr] == 0) m_unf = 1;
        else m_cnt[m_waddr]--;
      end
    end
    if (bus.mem_valid && bus.mem_writes) begin
      m_we = 1; m_waddr = int'(bus.mem_dest); m_wdata = bus.mem_data;
    end else begin
      m_we = 0;
    end
  endtask

  task automatic check_model();
    chk("issue_block", {31'b0, bus.issue_block},
        {31'b0, bus.issue_valid && bus.issue_writes && (m_cnt[bus.issue_dest] == 3)});
    chk("haz_a", {31'b0, bus.haz_a}, {31'b0, m_cnt[bus.qa_addr] != 0});
    chk("haz_b", {31'b0, bus.haz_b}, {31'b0, bus.qb_en && (m_cnt[bus.qb_addr] != 0)});
    chk("rf_we", {31'b0, bus.rf_we}, {31'b0, m_we});
    chk("wb_dvalid", {31'b0, bus.wb_dvalid}, {31'b0, m_we});
    chk("rf_waddr", {28'b0, bus.rf_waddr}, m_waddr);
    chk("Daddr_fromWB", {28'b0, bus.Daddr_fromWB}, m_waddr);
    chk("rf_wdata", bus.rf_wdata, m_wdata);
    chk("sb_underflow", {31'b0, bus.sb_underflow}, {31'b0, m_unf});
  endtask

  // Settle combinational outputs, compare against the model, then take one clock edge.
  task automatic cycle();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        iv iw id  qa qb qe  mv mw md mdata        blk ha hb we wa wdata       unf
    tbl[0]  = mk(1,1,5, 5,0,0, 0,0,0,32'h0,          0,0,0,0,0,32'h0,   0);
    tbl[1]  = mk(1,1,5, 5,0,0, 0,0,0,32'h0,          0,1,0,0,0,32'h0,   0);
    tbl[2]  = mk(1,1,5, 5,0,0, 0,0,0,32'h0,          0,1,0,0,0,32'h0,   0);
    tbl[3]  = mk(1,1,5, 5,0,0, 0,0,0,32'h0,          1,1,0,0,0,32'h0,   0);
    tbl[4]  = mk(0,1,5, 5,5,1, 0,0,0,32'h0,          0,1,1,0,0,32'h0,   0);
    tbl[5]  = mk(1,1,5, 5,0,0, 0,0,0,32'h0,          1,1,0,0,0,32'h0,   0);
    tbl[6]  = mk(1,0,5, 5,0,0, 0,0,0,32'h0,          0,1,0,0,0,32'h0,   0);
    tbl[7]  = mk(1,1,3, 3,0,0, 0,0,0,32'h0,          0,0,0,0,0,32'h0,   0);
    tbl[8]  = mk(0,0,0, 3,0,0, 0,0,0,32'h0,          0,1,0,0,0,32'h0,   0);
    tbl[9]  = mk(0,0,0, 3,0,0, 1,1,3,32'h0000_00AA,  0,1,0,0,0,32'h0,   0);
    tbl[10] = mk(0,0,0, 3,0,0, 0,0,0,32'h0,          0,1,0,1,3,32'hAA,  0);
    tbl[11] = mk(0,0,0, 3,0,0, 0,0,0,32'h0,          0,0,0,0,3,32'hAA,  0);
    tbl[12] = mk(0,0,0, 4,0,0, 1,0,4,32'h1234,       0,0,0,0,3,32'hAA,  0);
    tbl[13] = mk(0,0,0, 4,0,0, 0,0,0,32'h0,          0,0,0,0,3,32'hAA,  0);
    tbl[14] = mk(1,1,7, 7,0,0, 0,0,0,32'h0,          0,0,0,0,3,32'hAA,  0);
    tbl[15] = mk(0,0,0, 7,0,0, 1,1,7,32'h7,          0,1,0,0,3,32'hAA,  0);
    tbl[16] = mk(1,1,7, 7,0,0, 1,1,7,32'h8,          0,1,0,1,7,32'h7,   0);
    tbl[17] = mk(1,1,2, 7,2,1, 0,0,0,32'h0,          0,1,0,1,7,32'h8,   0);
    tbl[18] = mk(0,0,0, 7,2,1, 0,0,0,32'h0,          0,0,1,0,7,32'h8,   0);
    tbl[19] = mk(0,0,0, 9,9,0, 1,1,9,32'h9,          0,0,0,0,7,32'h8,   0);
    tbl[20] = mk(0,0,0, 9,9,0, 0,0,0,32'h0,          0,0,0,1,9,32'h9,   0);
    tbl[21] = mk(0,0,0, 9,9,0, 0,0,0,32'h0,          0,0,0,0,9,32'h9,   1);
    tbl[22] = mk(0,0,0, 9,9,1, 0,0,0,32'h0,          0,0,0,0,9,32'h9,   1);

    drive(0,0,0, 0,0,0, 0,0,0,32'h0);
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table: expectations written out by hand, model kept in lock-step.
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].iv, tbl[i].iw, tbl[i].idest, tbl[i].qa, tbl[i].qb, tbl[i].qben,
            tbl[i].mv, tbl[i].mw, tbl[i].mdest, tbl[i].mdata);
      #1;
      chk($sformatf("row%0d issue_block", i), {31'b0, bus.issue_block}, {31'b0, tbl[i].e_blk});
      chk($sformatf("row%0d haz_a", i), {31'b0, bus.haz_a}, {31'b0, tbl[i].e_ha});
      chk($sformatf("row%0d haz_b", i), {31'b0, bus.haz_b}, {31'b0, tbl[i].e_hb});
      chk($sformatf("row%0d rf_we", i), {31'b0, bus.rf_we}, {31'b0, tbl[i].e_we});
      chk($sformatf("row%0d wb_dvalid", i), {31'b0, bus.wb_dvalid}, {31'b0, tbl[i].e_we});
      chk($sformatf("row%0d rf_waddr", i), {28'b0, bus.rf_waddr}, {28'b0, tbl[i].e_waddr});
      chk($sformatf("row%0d Daddr", i), {28'b0, bus.Daddr_fromWB}, {28'b0, tbl[i].e_waddr});
      chk($sformatf("row%0d rf_wdata", i), bus.rf_wdata, tbl[i].e_wdata);
      chk($sformatf("row%0d sb_underflow", i), {31'b0, bus.sb_underflow}, {31'b0, tbl[i].e_unf});
      cycle();
    end

    // Reset mid-flight: R3 pending and a write in the latch, then one reset cycle.
    drive(1,1,3, 3,0,0, 0,0,0,32'h0);
    cycle();
    drive(0,0,0, 3,0,0, 1,1,3,32'hDEAD_BEEF);
    #1;
    chk("pre-reset haz_a R3", {31'b0, bus.haz_a}, 32'd1);
    cycle();
    chk("pre-reset rf_we", {31'b0, bus.rf_we}, 32'd1);
    rst = 1'b1;
    drive(1,1,3, 3,0,0, 1,1,3,32'h5555_5555);
    cycle();
    rst = 1'b0;
    drive(0,0,0, 3,5,1, 0,0,0,32'h0);
    #1;
    chk("post-reset haz_a R3", {31'b0, bus.haz_a}, 32'd0);
    chk("post-reset haz_b R5", {31'b0, bus.haz_b}, 32'd0);
    chk("post-reset rf_we", {31'b0, bus.rf_we}, 32'd0);
    chk("post-reset rf_wdata", bus.rf_wdata, 32'd0);
    chk("post-reset rf_waddr", {28'b0, bus.rf_waddr}, 32'd0);
    chk("post-reset sb_underflow", {31'b0, bus.sb_underflow}, 32'd0);
    cycle();

    // Random traffic; retires only target registers with an unretired pending writer.
    for (int n = 0; n < 2000; n++) begin
      logic iv, iw, qben, mv, mw;
      logic [3:0] idest, qa, qb, md;
      int start, pick;
      iv    = 1'($urandom_range(0, 1));
      iw    = ($urandom_range(0, 3) != 0);
      idest = 4'($urandom_range(0, NREGS - 1));
      qa    = 4'($urandom_range(0, NREGS - 1));
      qb    = 4'($urandom_range(0, NREGS - 1));
      qben  = 1'($urandom_range(0, 1));
      mv    = 1'($urandom_range(0, 1));
      mw    = ($urandom_range(0, 4) != 0);
      md    = 4'($urandom_range(0, NREGS - 1));
      if (mv && mw) begin
        pick  = -1;
        start = $urandom_range(0, NREGS - 1);
        for (int k = 0; k < NREGS; k++) begin
          int r;
          r = (start + k) % NREGS;
          if (pick < 0 && (m_cnt[r] - ((m_we && m_waddr == r) ? 1 : 0)) > 0) pick = r;
        end
        if (pick < 0) mw = 1'b0;
        else md = 4'(pick);
      end
      rst = ($urandom_range(0, 199) == 0);
      drive(iv, iw, idest, qa, qb, qben, mv, mw, md, $urandom);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
